pbus_lane_bridge: RTL and testbench
===================================

Name: pbus_lane_bridge

Overview:
- Registered bridge between the narrow peripheral data bus (PD) and the wide system data bus (SD).
- Steers each peripheral byte onto a selected SD byte lane. Runs one strobed peripheral cycle per lane with programmable wait states.
- Assembles wide reads from consecutive narrow accesses. Lanes not read return all-ones (pulled-high bus).
- Sits between the system bus decoder and the 8-bit peripheral port; parametrised successor of the fixed upper-lane steering logic.

Parameters:
PD_W, 8, peripheral data width (bits per lane)
LANES, 2, number of SD byte lanes; SD width SYS_W = PD_W*LANES; LANES >= 2
WAIT, 2, extra strobe cycles per peripheral access (0..15)
LW, $clog2(LANES), lane index width (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
sys_req  in  1  start access; sampled only in IDLE
sys_we  in  1  1 = write, 0 = read; captured with sys_req
sys_wide  in  1  1 = access all lanes 0..LANES-1; 0 = single lane
sys_lane  in  LW  lane for single access; captured with sys_req
sys_wdata  in  SYS_W  write data; captured with sys_req
sys_force_hi  in  1  forces sys_rdata to all-ones (combinational)
sys_rdata  out  SYS_W  assembled read data
sys_busy  out  1  high from the cycle after sys_req is accepted until DONE
sys_ack  out  1  one-cycle completion pulse
pd_addr  out  LW  lane index of the current peripheral cycle
pd_rd_n  out  1  peripheral read strobe, active-low
pd_wr_n  out  1  peripheral write strobe, active-low
pd_dout  out  PD_W  peripheral write data
pd_din  in  PD_W  peripheral read data

Behaviour:
- Reset values:
  - state IDLE; rdata register all-ones; pd_rd_n = pd_wr_n = 1.
  - pd_addr = 0; pd_dout = 0; sys_ack = 0; sys_busy = 0.
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - sys_req = 1 captures we/wide/lane/wdata.
  - Current lane = 0 if wide, else sys_lane.
  - A read clears the rdata register to all-ones.
  - Next state SETUP.
- SETUP (1 cycle): pd_addr = current lane; pd_dout = wdata slice of that lane; strobes high.
- STROBE (WAIT+1 cycles):
  - pd_rd_n or pd_wr_n low, per we. A 4-bit wait counter counts down from WAIT.
  - On the last STROBE cycle a read samples pd_din into rdata[lane*PD_W +: PD_W].
- HOLD (1 cycle):
  - Strobes high; pd_addr and pd_dout held.
  - If wide and lane < LANES-1: lane += 1, go to SETUP. Otherwise go to DONE.
- DONE (1 cycle): sys_ack = 1, then IDLE.
- Latency:
  - Single access: sys_ack asserts 4+WAIT cycles after the sys_req edge.
  - Wide access: LANES*(3+WAIT)+1 cycles.
- Output timing: strobes, pd_addr and pd_dout are registered. sys_rdata = rdata register OR {SYS_W{sys_force_hi}}.
- Boundary cases:
  - sys_req while busy: ignored; no queueing.
  - sys_req held high: a new access starts in the IDLE cycle after DONE.
  - Read data: lanes not accessed read all-ones; a single read changes only its own lane.
  - Write: sys_rdata unchanged.
  - WAIT = 0: strobe exactly 1 cycle.
  - Out-of-range sys_lane (LANES not a power of 2): the access completes with no strobe, sys_ack is still issued, and rdata stays all-ones.
- Reset mid-access: strobes return high immediately (asynchronous); no sys_ack; state IDLE.

Optional Feature:
- Macro: PBUS_LANE_SWAP_EN.
- Defined: peripheral lane k maps to SD bits [(LANES-1-k)*PD_W +: PD_W], for both the read placement and the write slice. pd_addr still carries k.
- Undefined: lane k maps to SD bits [k*PD_W +: PD_W].
- Latency and sequencing are identical either way.

Test Plan:
- Reset then idle -> sys_rdata = 16'hFFFF; pd_rd_n = pd_wr_n = 1; sys_ack = 0.
- Single read, lane=1, pd_din=8'hA5, WAIT=2 -> pd_rd_n low for 3 cycles, pd_addr=1; sys_ack 6 cycles after req; sys_rdata = 16'hA5FF.
- Wide write, sys_wdata=16'h1234 -> two strobes: pd_addr=0/pd_dout=8'h34, then pd_addr=1/pd_dout=8'h12; ack at cycle 11; sys_rdata unchanged.
- Wide read, pd_din 8'h3C then 8'hC3, with sys_force_hi pulsed mid-access:
  - During the pulse: sys_rdata = 16'hFFFF.
  - After completion: sys_rdata = 16'hC33C.
- sys_req re-pulsed while busy -> exactly one ack. rst_n low during STROBE -> strobes high the same cycle, no ack, next req accepted.
- PBUS_LANE_SWAP_EN, wide read of 8'h11, 8'h22 -> sys_rdata = 16'h1122.

Source files
------------

// File: rtl/pbus_lane_bridge.sv
// ---------------------------------------------------------------------------
// pbus_lane_bridge
//
// Purpose:
//   This is a registered bridge between a narrow peripheral data bus (PD) and
//   a wide system data bus (SD).
//   - Each system access runs one strobed peripheral cycle per byte lane.
//   - The strobe is held for WAIT extra cycles.
//   - A wide access walks lanes 0..LANES-1 in order.
//   - A single access touches only sys_lane.
//   - Read bytes are assembled into an SD-wide register. That register is
//     all-ones at the start of every read, so lanes that are not read return
//     the pulled-high value.
//
// Optional feature:
//   `define PBUS_LANE_SWAP_EN  - peripheral lane k maps to SD lane LANES-1-k
//                                for both read placement and write slicing.
//                                pd_addr still carries k.
//   undefined (default)        - peripheral lane k maps to SD lane k.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   sys_req       start access (sampled only in IDLE)
//   sys_we        1 = write, 0 = read
//   sys_wide      1 = all lanes, 0 = single lane sys_lane
//   sys_lane      lane for a single access
//   sys_wdata     SD-wide write data
//   sys_force_hi  combinationally forces sys_rdata to all-ones
//   sys_rdata     assembled read data
//   sys_busy      access in progress (accept+1 .. DONE)
//   sys_ack       one-cycle completion pulse
//   pd_addr       lane index of the current peripheral cycle
//   pd_rd_n       peripheral read strobe, active-low
//   pd_wr_n       peripheral write strobe, active-low
//   pd_dout       peripheral write data
//   pd_din        peripheral read data
// ---------------------------------------------------------------------------
module pbus_lane_bridge #(
  parameter  int PD_W  = 8,
  parameter  int LANES = 2,
  parameter  int WAIT  = 2,
  localparam int LW    = $clog2(LANES),
  localparam int SYS_W = PD_W * LANES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sys_req,
  input  logic             sys_we,
  input  logic             sys_wide,
  input  logic [LW-1:0]    sys_lane,
  input  logic [SYS_W-1:0] sys_wdata,
  input  logic             sys_force_hi,
  output logic [SYS_W-1:0] sys_rdata,
  output logic             sys_busy,
  output logic             sys_ack,
  output logic [LW-1:0]    pd_addr,
  output logic             pd_rd_n,
  output logic             pd_wr_n,
  output logic [PD_W-1:0]  pd_dout,
  input  logic [PD_W-1:0]  pd_din
);

  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic               r_we;
  logic               r_wide;
  logic [LW-1:0]      r_lane;
  logic [SYS_W-1:0]   r_wdata;
  logic [3:0]         r_wait;
  logic [SYS_W-1:0]   r_rdata;
  logic               r_rd_n;
  logic               r_wr_n;
  logic [LW-1:0]      r_addr;
  logic [PD_W-1:0]    r_dout;
  logic               r_ack;
  logic               r_busy;

  logic [LW-1:0]      w_lane_nx;
  logic [SYS_W-1:0]   w_wdata_nx;
  logic [PD_W-1:0]    w_dout_nx;
  logic               w_more_lanes;
  logic               w_lane_ok;

  // Maps a peripheral lane index to the SD lane it occupies. An out-of-range
  // index maps to an out-of-range SD lane in both modes, so the lane loops
  // below never match it.
  function automatic logic [LW-1:0] f_sd_lane(input logic [LW-1:0] k);
`ifdef PBUS_LANE_SWAP_EN
    return LAST_LANE - k;
`else
    return k;
`endif
  endfunction

  // A lane index can only be out of range when LANES is not a power of two.
  // Such an access still sequences to DONE, but it never drives a strobe.
  if (LANES == (1 << LW)) begin : g_lane_pow2
    assign w_lane_ok = 1'b1;
  end else begin : g_lane_npow2
    assign w_lane_ok = (r_lane <= LAST_LANE);
  end

  assign w_more_lanes = r_wide && (r_lane < LAST_LANE);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (sys_req) w_state_nx = S_SETUP;
      S_SETUP:  w_state_nx = S_STROBE;
      S_STROBE: if (r_wait == 4'd0) w_state_nx = S_HOLD;
      S_HOLD:   w_state_nx = w_more_lanes ? S_SETUP : S_DONE;
      S_DONE:   w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // The lane and the write data for the next SETUP cycle come either from the
  // request being accepted (IDLE) or from the access already in flight.
  // pd_addr and pd_dout can therefore be registered on the edge that enters
  // SETUP.
  always_comb begin
    w_lane_nx = r_lane;
    case (r_state)
      S_IDLE:  w_lane_nx = sys_wide ? '0 : sys_lane;
      S_HOLD:  if (w_more_lanes) w_lane_nx = r_lane + LW'(1);
      default: w_lane_nx = r_lane;
    endcase
  end

  assign w_wdata_nx = (r_state == S_IDLE) ? sys_wdata : r_wdata;

  always_comb begin
    w_dout_nx = '0;
    for (int l = 0; l < LANES; l++) begin
      if (LW'(l) == f_sd_lane(w_lane_nx)) w_dout_nx = w_wdata_nx[l*PD_W +: PD_W];
    end
  end

  // Access capture, wait counter, strobes and read assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_wide  <= 1'b0;
      r_lane  <= '0;
      r_wdata <= '0;
      r_wait  <= 4'd0;
      r_rdata <= '1;
      r_rd_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_addr  <= '0;
      r_dout  <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_lane <= w_lane_nx;
      r_ack  <= (r_state == S_DONE);

      if (r_state == S_IDLE && sys_req) begin
        r_we    <= sys_we;
        r_wide  <= sys_wide;
        r_wdata <= sys_wdata;
        r_busy  <= 1'b1;
        if (!sys_we) r_rdata <= '1;
      end else if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end

      if (w_state_nx == S_SETUP) begin
        r_addr <= w_lane_nx;
        r_dout <= w_dout_nx;
      end

      if (r_state == S_SETUP) begin
        r_wait <= 4'(WAIT);
      end else if (r_state == S_STROBE && r_wait != 4'd0) begin
        r_wait <= r_wait - 4'd1;
      end

      // The strobes are registered from the next state, so they go low on
      // exactly the STROBE cycles.
      r_rd_n <= !((w_state_nx == S_STROBE) && !r_we && w_lane_ok);
      r_wr_n <= !((w_state_nx == S_STROBE) &&  r_we && w_lane_ok);

      if (r_state == S_STROBE && r_wait == 4'd0 && !r_we) begin
        for (int l = 0; l < LANES; l++) begin
          if (LW'(l) == f_sd_lane(r_lane)) r_rdata[l*PD_W +: PD_W] <= pd_din;
        end
      end
    end
  end

  assign sys_rdata = r_rdata | {SYS_W{sys_force_hi}};
  assign sys_busy  = r_busy;
  assign sys_ack   = r_ack;
  assign pd_addr   = r_addr;
  assign pd_rd_n   = r_rd_n;
  assign pd_wr_n   = r_wr_n;
  assign pd_dout   = r_dout;

endmodule

// File: tb/tb_pbus_lane_bridge.sv
// ---------------------------------------------------------------------------
// tb_pbus_lane_bridge
//
// Directed bench for pbus_lane_bridge at its default configuration:
// PD_W=8, LANES=2, WAIT=2.
// - The peripheral is modelled as a two-entry read-data table indexed by
//   pd_addr.
// - Expected lane placements follow PBUS_LANE_SWAP_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_pbus_lane_bridge;

  localparam int PD_W  = 8;
  localparam int LANES = 2;
  localparam int LW    = 1;
  localparam int SYS_W = 16;

`ifdef PBUS_LANE_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sys_req;
  logic             sys_we;
  logic             sys_wide;
  logic [LW-1:0]    sys_lane;
  logic [SYS_W-1:0] sys_wdata;
  logic             sys_force_hi;
  logic [SYS_W-1:0] sys_rdata;
  logic             sys_busy;
  logic             sys_ack;
  logic [LW-1:0]    pd_addr;
  logic             pd_rd_n;
  logic             pd_wr_n;
  logic [PD_W-1:0]  pd_dout;
  logic [PD_W-1:0]  pd_din;

  logic [PD_W-1:0]  din0;
  logic [PD_W-1:0]  din1;

  assign pd_din = (pd_addr == 1'b0) ? din0 : din1;

  always #5 clk = ~clk;

  pbus_lane_bridge #(.PD_W(PD_W), .LANES(LANES), .WAIT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sys_req      (sys_req),
    .sys_we       (sys_we),
    .sys_wide     (sys_wide),
    .sys_lane     (sys_lane),
    .sys_wdata    (sys_wdata),
    .sys_force_hi (sys_force_hi),
    .sys_rdata    (sys_rdata),
    .sys_busy     (sys_busy),
    .sys_ack      (sys_ack),
    .pd_addr      (pd_addr),
    .pd_rd_n      (pd_rd_n),
    .pd_wr_n      (pd_wr_n),
    .pd_dout      (pd_dout),
    .pd_din       (pd_din)
  );

  int checks = 0;
  int errors = 0;

  int ack_cyc;
  int ack_cnt;
  int rd_low;
  int wr_low;
  int nseg;
  logic [LW-1:0]   seg_addr [4];
  logic [PD_W-1:0] seg_dout [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and then watches 20 cycles.
  // - Cycle k is sampled 1 ns after the k-th edge that follows the edge which
  //   accepts the request.
  // - repulse_k re-asserts sys_req for one cycle while the access is busy.
  // - force_k pulses sys_force_hi after checking the partial read data.
  task automatic access(input logic we, input logic wide, input logic [LW-1:0] lane,
                        input logic [SYS_W-1:0] wdata, input int repulse_k,
                        input int force_k, input logic [SYS_W-1:0] pre_force);
    logic prev_low;
    sys_req   = 1'b1;
    sys_we    = we;
    sys_wide  = wide;
    sys_lane  = lane;
    sys_wdata = wdata;
    step();
    chk("busy_after_accept", sys_busy, 1);
    sys_req  = 1'b0;
    ack_cyc  = -1;
    ack_cnt  = 0;
    rd_low   = 0;
    wr_low   = 0;
    nseg     = 0;
    prev_low = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == repulse_k) sys_req = 1'b1;
      step();
      if (k == repulse_k) sys_req = 1'b0;
      if (sys_ack) begin
        ack_cnt++;
        if (ack_cyc < 0) ack_cyc = k;
      end
      if (!pd_rd_n) rd_low++;
      if (!pd_wr_n) wr_low++;
      if ((!pd_rd_n || !pd_wr_n) && !prev_low && nseg < 4) begin
        seg_addr[nseg] = pd_addr;
        seg_dout[nseg] = pd_dout;
        nseg++;
      end
      prev_low = !pd_rd_n || !pd_wr_n;
      if (k == force_k) begin
        chk("rdata_before_force", sys_rdata, pre_force);
        sys_force_hi = 1'b1;
        #1;
        chk("force_hi_all_ones", sys_rdata, 16'hFFFF);
        sys_force_hi = 1'b0;
        #1;
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    sys_req      = 1'b0;
    sys_we       = 1'b0;
    sys_wide     = 1'b0;
    sys_lane     = '0;
    sys_wdata    = '0;
    sys_force_hi = 1'b0;
    din0         = 8'h00;
    din1         = 8'h00;

    // Reset state
    repeat (3) step();
    chk("rst_rdata", sys_rdata, 16'hFFFF);
    chk("rst_rd_n", pd_rd_n, 1);
    chk("rst_wr_n", pd_wr_n, 1);
    chk("rst_ack", sys_ack, 0);
    chk("rst_busy", sys_busy, 0);
    chk("rst_addr", pd_addr, 0);
    chk("rst_dout", pd_dout, 0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_ack", sys_ack, 0);

    // Single read of lane 1, with a request re-pulsed while busy
    din1 = 8'hA5;
    access(1'b0, 1'b0, 1'b1, 16'h0000, 2, 0, 16'h0000);
    chk("sr_ack_cycle", ack_cyc, 6);
    chk("sr_ack_count", ack_cnt, 1);
    chk("sr_rd_low", rd_low, 3);
    chk("sr_wr_low", wr_low, 0);
    chk("sr_segments", nseg, 1);
    chk("sr_addr", seg_addr[0], 1);
    chk("sr_rdata", sys_rdata, SWAP ? 16'hFFA5 : 16'hA5FF);

    // Wide write
    access(1'b1, 1'b1, 1'b0, 16'h1234, 0, 0, 16'h0000);
    chk("ww_ack_cycle", ack_cyc, 11);
    chk("ww_ack_count", ack_cnt, 1);
    chk("ww_wr_low", wr_low, 6);
    chk("ww_rd_low", rd_low, 0);
    chk("ww_segments", nseg, 2);
    chk("ww_addr0", seg_addr[0], 0);
    chk("ww_dout0", seg_dout[0], SWAP ? 8'h12 : 8'h34);
    chk("ww_addr1", seg_addr[1], 1);
    chk("ww_dout1", seg_dout[1], SWAP ? 8'h34 : 8'h12);
    chk("ww_rdata_kept", sys_rdata, SWAP ? 16'hFFA5 : 16'hA5FF);

    // Wide read with a force-high pulse after lane 0 has landed
    din0 = 8'h3C;
    din1 = 8'hC3;
    access(1'b0, 1'b1, 1'b0, 16'h0000, 0, 7, SWAP ? 16'h3CFF : 16'hFF3C);
    chk("wr_ack_cycle", ack_cyc, 11);
    chk("wr_rd_low", rd_low, 6);
    chk("wr_segments", nseg, 2);
    chk("wr_rdata", sys_rdata, SWAP ? 16'h3CC3 : 16'hC33C);

    // Wide read with a second data pattern
    din0 = 8'h11;
    din1 = 8'h22;
    access(1'b0, 1'b1, 1'b0, 16'h0000, 0, 0, 16'h0000);
    chk("wr2_rdata", sys_rdata, SWAP ? 16'h1122 : 16'h2211);

    // Single read of lane 0 clears the other lane back to all-ones
    din0 = 8'h5A;
    access(1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, 16'h0000);
    chk("sr0_ack_cycle", ack_cyc, 6);
    chk("sr0_addr", seg_addr[0], 0);
    chk("sr0_rdata", sys_rdata, SWAP ? 16'h5AFF : 16'hFF5A);

    // Reset asserted during STROBE
    sys_req  = 1'b1;
    sys_we   = 1'b0;
    sys_wide = 1'b0;
    sys_lane = 1'b1;
    step();
    sys_req = 1'b0;
    step();
    step();
    chk("mid_strobe_low", pd_rd_n, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobe_high", pd_rd_n, 1);
    chk("mid_rst_busy", sys_busy, 0);
    chk("mid_rst_rdata", sys_rdata, 16'hFFFF);
    #2;
    rst_n   = 1'b1;
    ack_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (sys_ack) ack_cnt++;
    end
    chk("mid_rst_no_ack", ack_cnt, 0);

    // Next request after the mid-access reset is accepted
    din0 = 8'h77;
    access(1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, 16'h0000);
    chk("post_rst_ack_cycle", ack_cyc, 6);
    chk("post_rst_rdata", sys_rdata, SWAP ? 16'h77FF : 16'hFF77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
